// File: rtl/hazard_control_if.sv
// Hazard controller signal bundle: ID/EX hazard inputs and pipeline stall/flush controls.
// The stall/flush statistics counters exist only when HAZARD_STATS_EN is defined.
interface hazard_control_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        jump_in_id;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, jump_in_id,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, busy
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_cycles
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, jump_in_id,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, busy
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_cycles
`endif
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: Mealy stall/flush decode with a RUN/STALL/FLUSH window FSM.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_cycles counters.
module hazard_control_unit #(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned BRANCH_PENALTY   = 1
) (
    input  logic            clk,
    input  logic            reset,
    hazard_control_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LU_LOAD = 4'(LOAD_USE_BUBBLES - 1);
    localparam logic [3:0] BR_LOAD = 4'(BRANCH_PENALTY - 1);

    generate
        if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 15) begin : g_lu_range
            $error("hazard_control_unit: LOAD_USE_BUBBLES must be in 1..15");
        end
        if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 15) begin : g_br_range
            $error("hazard_control_unit: BRANCH_PENALTY must be in 1..15");
        end
    endgenerate

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu_hit;
    logic       branch_go;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, busy;

    always_comb begin
        lu_hit = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                 ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    end

    // A taken branch wins in RUN and STALL; FLUSH already squashes those slots.
    always_comb begin
        branch_go = hz.branch_taken && (state != FLUSH);
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        busy        = (state != RUN);
        state_nxt   = state;
        cnt_nxt     = cnt;

        if (branch_go) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = BR_LOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (lu_hit) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = LU_LOAD;
                        end
                    end else if (hz.jump_in_id) begin
                        if_id_flush = 1'b1;
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    cnt_nxt     = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = RUN;
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    cnt_nxt     = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        if (!reset) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            busy        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.busy        = busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush && (flush_cycles != '1)) flush_cycles <= flush_cycles + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_cycles = flush_cycles;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three parameterisations share one stimulus stream and are
// checked every cycle against a stall/flush-window model plus hand-computed literals.
module tb_hazard_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, jump_in_id;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_control_if i1 ();
    hazard_control_if i3 ();
    hazard_control_if i4 ();

    hazard_control_unit #(.LOAD_USE_BUBBLES(1), .BRANCH_PENALTY(1)) d1 (.clk(clk), .reset(reset), .hz(i1));
    hazard_control_unit #(.LOAD_USE_BUBBLES(3), .BRANCH_PENALTY(2)) d3 (.clk(clk), .reset(reset), .hz(i3));
    hazard_control_unit #(.LOAD_USE_BUBBLES(4), .BRANCH_PENALTY(3)) d4 (.clk(clk), .reset(reset), .hz(i4));

    always_comb begin
        i1.id_rs = id_rs; i1.id_rt = id_rt; i1.id_uses_rt = id_uses_rt; i1.ex_mem_read = ex_mem_read;
        i1.ex_rt = ex_rt; i1.branch_taken = branch_taken; i1.jump_in_id = jump_in_id;
        i3.id_rs = id_rs; i3.id_rt = id_rt; i3.id_uses_rt = id_uses_rt; i3.ex_mem_read = ex_mem_read;
        i3.ex_rt = ex_rt; i3.branch_taken = branch_taken; i3.jump_in_id = jump_in_id;
        i4.id_rs = id_rs; i4.id_rt = id_rt; i4.id_uses_rt = id_uses_rt; i4.ex_mem_read = ex_mem_read;
        i4.ex_rt = ex_rt; i4.branch_taken = branch_taken; i4.jump_in_id = jump_in_id;
    end

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, busy}
    logic [4:0] a1, a3, a4;
    assign a1 = {i1.pc_write, i1.if_id_write, i1.if_id_flush, i1.id_ex_flush, i1.busy};
    assign a3 = {i3.pc_write, i3.if_id_write, i3.if_id_flush, i3.id_ex_flush, i3.busy};
    assign a4 = {i4.pc_write, i4.if_id_write, i4.if_id_flush, i4.id_ex_flush, i4.busy};

    // Model: remaining stall and flush cycles still owed after the current one.
    int lu_p [3] = '{1, 3, 4};
    int bp_p [3] = '{1, 2, 3};
    int stall_left [3] = '{0, 0, 0};
    int flush_left [3] = '{0, 0, 0};
    logic [31:0] stall_m = '0, flush_m = '0;

    function automatic logic hazard();
        if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
        return (ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt);
    endfunction

    function automatic logic [4:0] expected(input int k);
        logic windowed;
        windowed = (stall_left[k] > 0) || (flush_left[k] > 0);
        if (!reset)                  return 5'b11000;
        if (flush_left[k] > 0)       return 5'b11101;
        if (branch_taken)            return {4'b1111, windowed};
        if (stall_left[k] > 0)       return 5'b00011;
        if (hazard())                return 5'b00010;
        if (jump_in_id)              return 5'b11100;
        return 5'b11000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] act_of(input int k);
        case (k)
            0:       return a1;
            1:       return a3;
            default: return a4;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            chk($sformatf("model_d%0d", lu_p[k]), {27'd0, act_of(k)}, {27'd0, expected(k)});
`ifdef HAZARD_STATS_EN
        chk("model_stall_cycles", i1.stall_cycles, stall_m);
        chk("model_flush_cycles", i1.flush_cycles, flush_m);
`endif
    end

    always @(posedge clk) begin
        logic [4:0] e;
        e = expected(0);
        if (!reset) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
            if (!e[4] && stall_m != '1) stall_m = stall_m + 1;
            if (e[2] && flush_m != '1)  flush_m = flush_m + 1;
        end
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                stall_left[k] = 0;
                flush_left[k] = 0;
            end else if (flush_left[k] > 0) begin
                flush_left[k]--;
            end else if (branch_taken) begin
                flush_left[k] = bp_p[k] - 1;
                stall_left[k] = 0;
            end else if (stall_left[k] > 0) begin
                stall_left[k]--;
            end else if (hazard()) begin
                stall_left[k] = lu_p[k] - 1;
            end
        end
    end

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; jump_in_id = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rs8();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        branch_taken = 1'b1;
        jump_in_id = 1'b1;
        @(negedge clk);
        chk("reset_forced_d1", {27'd0, a1}, 32'h18);
        chk("reset_forced_d4", {27'd0, a4}, 32'h18);
        tick();
        tick();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("idle_d1", {27'd0, a1}, 32'h18);

        // Load-use on rs: d1 stalls one cycle, d3 three cycles, d4 four.
        tick(); load_use_rs8();
        @(negedge clk);
        chk("lu_cycle0_d1", {27'd0, a1}, 32'h02);
        chk("lu_cycle0_d3", {27'd0, a3}, 32'h02);
        tick(); idle();
        @(negedge clk);
        chk("lu_cycle1_d1", {27'd0, a1}, 32'h18);
        chk("lu_cycle1_d3", {27'd0, a3}, 32'h03);
        tick();
        @(negedge clk);
        chk("lu_cycle2_d3", {27'd0, a3}, 32'h03);
        tick();
        @(negedge clk);
        chk("lu_cycle3_d3", {27'd0, a3}, 32'h18);
        chk("lu_cycle3_d4", {27'd0, a4}, 32'h03);
        tick();

        // Register 0 never hazards; rt only counts when the ID instruction reads it.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        @(negedge clk);
        chk("r0_no_stall_d4", {27'd0, a4}, 32'h18);
        tick();
        ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        @(negedge clk);
        chk("rt_unused_d1", {27'd0, a1}, 32'h18);
        tick();
        id_uses_rt = 1'b1;
        @(negedge clk);
        chk("rt_used_d3", {27'd0, a3}, 32'h02);
        tick(); idle();
        repeat (4) tick();

        // Branch: d3 flushes two cycles and ignores a second branch in the window.
        branch_taken = 1'b1;
        @(negedge clk);
        chk("br_cycle0_d3", {27'd0, a3}, 32'h1E);
        tick();
        @(negedge clk);
        chk("br_cycle1_d3", {27'd0, a3}, 32'h1D);
        chk("br_again_d1", {27'd0, a1}, 32'h1E);
        tick(); branch_taken = 1'b0;
        @(negedge clk);
        chk("br_cycle2_d3", {27'd0, a3}, 32'h18);
        tick(); tick();

        // Branch in second stall cycle of d4, then reset mid-FLUSH.
        load_use_rs8();
        tick(); idle(); branch_taken = 1'b1;
        @(negedge clk);
        chk("stall_branch_d4", {27'd0, a4}, 32'h1F);
        tick(); branch_taken = 1'b0;
        @(negedge clk);
        chk("flush_d4", {27'd0, a4}, 32'h1D);
        tick(); reset = 1'b0;
        #1;
        chk("reset_mid_flush_d4", {27'd0, a4}, 32'h18);
        tick(); reset = 1'b1;
        @(negedge clk);
        chk("post_reset_d4", {27'd0, a4}, 32'h18);
        tick();

        // Jump alone flushes IF/ID; jump with load-use stalls instead.
        jump_in_id = 1'b1;
        @(negedge clk);
        chk("jump_d1", {27'd0, a1}, 32'h1C);
        tick(); load_use_rs8();
        @(negedge clk);
        chk("jump_lu_d1", {27'd0, a1}, 32'h02);
        tick(); idle();
        repeat (4) tick();

        // Mixed traffic checked by the model every cycle.
        for (int n = 0; n < 300; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            jump_in_id   = ($urandom_range(0, 5) == 0);
            reset        = ($urandom_range(0, 49) != 0);
            tick();
        end
        idle();
        reset = 1'b1;
        repeat (5) tick();

`ifdef HAZARD_STATS_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            load_use_rs8();
            tick(); idle();
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            branch_taken = 1'b1;
            tick(); idle();
            tick();
        end
        @(negedge clk);
        chk("stats_stall_d1", i1.stall_cycles, 32'd3);
        chk("stats_flush_d1", i1.flush_cycles, 32'd2);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller. Consumes the EX-stage fields held by the ID/EX register (mem_read, rt, branch outcome) together with the ID-stage register indices.
- Drives the stall and flush controls for the PC, IF/ID and ID/EX registers.
- A small FSM supports multi-cycle load-use stalls and multi-cycle branch flush windows. The stall/flush decision for the current cycle is combinational (Mealy); the state and counter are registered.

Parameters:
- LOAD_USE_BUBBLES, 1, stall cycles inserted per load-use hazard; legal range 1..15.
- BRANCH_PENALTY, 1, cycles IF/ID stays flushed after a taken branch; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne).
- ex_mem_read  in  1  mem_read of the instruction in EX (ID/EX output).
- ex_rt  in  5  rt of the instruction in EX (ID/EX output).
- branch_taken  in  1  branch resolved taken this cycle.
- jump_in_id  in  1  ID holds j/jal.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID synchronous clear to NOP.
- id_ex_flush  out  1  ID/EX clear to bubble; all control fields 0.
- busy  out  1  FSM not in RUN.

Behaviour:
- States: RUN, STALL, FLUSH. 4-bit down-counter cnt.
- Reset (reset==0): state=RUN, cnt=0. While reset is low, outputs are forced to pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, busy=0.
- Reset asserted mid-STALL or mid-FLUSH aborts to RUN immediately. There is no residual stall after release.
- lu_hit = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority is branch_taken > load-use > jump.
- RUN:
  - branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. If BRANCH_PENALTY>1, next state=FLUSH with cnt=BRANCH_PENALTY-1.
  - else lu_hit: pc_write=0, if_id_write=0, id_ex_flush=1. If LOAD_USE_BUBBLES>1, next state=STALL with cnt=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
  - else jump_in_id: if_id_flush=1 for one cycle, pc_write=1.
  - else: pc_write=1, if_id_write=1, both flushes 0.
- STALL:
  - pc_write=0, if_id_write=0, id_ex_flush=1, busy=1. Each cycle cnt decrements; when cnt==1, next state=RUN.
  - lu_hit is not re-evaluated in STALL.
  - branch_taken in STALL overrides: it behaves exactly as branch_taken in RUN (pc_write=1, both flushes, FLUSH entry if penalty>1), and the remaining stall is discarded.
- FLUSH:
  - if_id_flush=1, pc_write=1, if_id_write=1, id_ex_flush=0, busy=1. cnt decrements; at cnt==1, next state=RUN.
  - branch_taken and jump_in_id are ignored, since slots are already squashed. lu_hit is ignored, since ID holds a NOP.
- Counter never underflows: legal entry values are ≥1.
- Parameters outside 1..15 are a $error at elaboration.
- Simultaneous lu_hit and jump_in_id: the stall wins. The jump is re-presented next cycle and flushed then.
- Register 0 is never a hazard source.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, the block adds ports stall_cycles (out, 32) and flush_cycles (out, 32). Both reset to 0.
  - stall_cycles increments on every clock where pc_write==0.
  - flush_cycles increments on every clock where if_id_flush==1.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Defaults; ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (ex_mem_read=0) all normal, busy never 1.
- Defaults; ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_write=1.
- LOAD_USE_BUBBLES=3; one-cycle lu_hit (id_rt=9, ex_rt=9, id_uses_rt=1) -> pc_write=0 for exactly 3 cycles, busy=1 on cycles 2-3, then RUN.
- BRANCH_PENALTY=2; branch_taken pulse -> cycle 0: if_id_flush=1, id_ex_flush=1; cycle 1: if_id_flush=1, id_ex_flush=0, busy=1; cycle 2: normal. A second branch_taken on cycle 1 is ignored.
- LOAD_USE_BUBBLES=4; branch_taken in the second STALL cycle -> pc_write=1 and both flushes that cycle, stall abandoned; reset pulled low mid-FLUSH -> busy=0 immediately.
- HAZARD_STATS_EN, defaults; 3 load-use events and 2 taken branches -> stall_cycles=3, flush_cycles=2.
